mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle load/store unit between the CPU datapath and the CPU-side port of the byte-order swap stage feeding data RAM.
- Converts a CPU memory op (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) into one word-aligned Avalon-style bus transaction.
- Honours waitrequest, stalls the CPU until completion, then returns the extracted, extended or merged load result.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: max consecutive waitrequest-high cycles in REQ before abort. 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op_valid  in  1  CPU presents an op. Held until stall is low.
- op_type  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW. Other codes are no-op.
- op_addr  in  32  byte address.
- op_wdata  in  32  store data, taken from rt.
- op_rt_old  in  32  current rt value, used for the LWL/LWR merge.
- stall  out  1  CPU must hold its pipeline.
- result_valid  out  1  one-cycle pulse; result_data valid for a load.
- result_data  out  32  load result.
- fault  out  1  one-cycle pulse marking an aborted op.
- fault_cause  out  2  01 misaligned, 10 timeout. 00 when no fault.
- mem_address  out  32  {addr[31:2],2'b00}.
- mem_read  out  1  read request.
- mem_write  out  1  write request.
- mem_byteenable  out  4  bit i enables lane i.
- mem_writedata  out  32  store data.
- mem_readdata  in  32  read data.
- mem_waitrequest  in  1  high means the bus has not accepted the request.

Behaviour:
- Lane convention: lane i is bits [8i+7:8i] and holds the byte at word base + i. k = addr[1:0].
- States: IDLE, REQ, DONE.
- IDLE:
  - stall = op_valid.
  - On op_valid, register op, addr, wdata and rt_old.
  - Misaligned op goes to DONE with fault_cause 01 and no bus access. Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with k≠0.
  - Undefined op_type goes to DONE with no bus access and no fault.
  - Otherwise go to REQ and clear the timeout counter.
- REQ:
  - stall = 1.
  - mem_read (loads) or mem_write (stores) asserted. Address, byteenable and writedata are driven from registers and stable while waitrequest is high.
  - When waitrequest is low: capture readdata on loads, then go to DONE.
  - When waitrequest is high: increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT, drop the request and go to DONE with fault_cause 10.
- DONE:
  - stall = 0.
  - result_valid = 1 only for a successful load.
  - fault pulses if a cause is latched.
  - op_valid is ignored this cycle. Next state is IDLE.
- Minimum latency: op accepted in cycle 0, REQ in cycle 1 with waitrequest low, DONE in cycle 2. Back-to-back ops cost 3 cycles each.
- Store lanes:
  - SB: byteenable = 1<<k, writedata = {4{wdata[7:0]}}.
  - SH: byteenable = 0011 (k=0) or 1100 (k=2), writedata = {2{wdata[15:0]}}.
  - SW: byteenable = 1111, writedata = wdata.
- Load results, with W = captured readdata:
  - LB/LBU: sign- or zero-extend lane k.
  - LH/LHU: extend {lane k+1, lane k}.
  - LW: W.
  - LWL: result[31:8(3-k)] = W[8k+7:0]; lower bits come from rt_old.
  - LWR: result[31-8k:0] = W[31:8k]; upper 8k bits come from rt_old.
- Loads drive byteenable = 1111.
- Reset values and behaviour:
  - Every output is 0; state is IDLE.
  - Reset asserted mid-REQ drops mem_read/mem_write immediately and abandons the transaction.
- result_data holds its value outside DONE.
- mem_read and mem_write are never both high.

Test Plan:
- LW addr 0x100, waitrequest low, readdata 0x44332211 -> mem_address 0x100, mem_read 1 in cycle 1, result_valid and result_data 0x44332211 in cycle 2, stall high in cycles 0-1.
- LB addr 0x103 with readdata 0x80332211 -> 0xFFFFFF80. LBU -> 0x00000080. LH addr 0x102 -> 0xFFFF8033.
- SH addr 0x202, wdata 0x1234ABCD -> byteenable 1100, writedata 0xABCDABCD, mem_write held through 3 waitrequest-high cycles, completes in the 5th cycle.
- LWL k=1 and LWR k=1, readdata 0x44332211, rt_old 0xAABBCCDD -> 0x2211CCDD and 0xAA443322.
- LW addr 0x101 -> no mem_read, fault pulse with cause 01 in cycle 1, result_valid 0.
- TIMEOUT=4 with waitrequest stuck high -> mem_read for 4 REQ cycles, then fault cause 10. Separately, reset asserted mid-REQ -> mem_read drops the same cycle, stall 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - word-aligned load/store unit with byte-lane steering and bus watchdog
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_rt_old,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]    op_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rt_q;
    logic [31:0]   result_q;
    logic [1:0]    cause_q;
    logic          ok_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic [1:0]    k_q;
    logic [3:0]    st_be;
    logic [31:0]   st_wd;

    assign k_q         = addr_q[1:0];
    assign result_data = result_q;

    function automatic logic is_load(input logic [3:0] op);
        return op <= OP_LWR;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] k);
        case (op)
            OP_LH, OP_LHU, OP_SH: return k[0];
            OP_LW, OP_SW:         return k != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    // LWL/LWR keep the rt_old bytes that the unaligned word does not cover
    function automatic logic [31:0] load_result(input logic [3:0] op, input logic [1:0] k,
                                                input logic [31:0] w, input logic [31:0] rt);
        logic [4:0]  sh;
        logic [4:0]  sl;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = {k, 3'b000};
        sl = {~k, 3'b000};
        b  = 8'(w >> sh);
        h  = 16'(w >> sh);
        r  = w;
        case (op)
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h0, b};
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0, h};
            OP_LWL:  r = (w << sl) | (rt & ~(32'hFFFF_FFFF << sl));
            OP_LWR:  r = (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            default: r = w;
        endcase
        return r;
    endfunction

    always_comb begin
        st_be = 4'b1111;
        st_wd = '0;
        case (op_q)
            OP_SB: begin
                st_be = 4'b0001 << k_q;
                st_wd = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                st_be = k_q[1] ? 4'b1100 : 4'b0011;
                st_wd = {2{wdata_q[15:0]}};
            end
            OP_SW:   st_wd = wdata_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        stall          = 1'b0;
        result_valid   = 1'b0;
        fault          = 1'b0;
        fault_cause    = 2'b00;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        timeout_hit    = 1'b0;
        cnt_inc        = cnt_q + CW'(1);
        case (state)
            IDLE: begin
                stall = op_valid & ~reset;
                if (op_valid) begin
                    if (misaligned(op_type, op_addr[1:0]) ||
                        !(is_load(op_type) || is_store(op_type)))
                        state_nxt = DONE;
                    else
                        state_nxt = REQ;
                end
            end
            REQ: begin
                stall          = 1'b1;
                mem_read       = is_load(op_q);
                mem_write      = is_store(op_q);
                mem_address    = {addr_q[31:2], 2'b00};
                mem_byteenable = st_be;
                mem_writedata  = st_wd;
                if (!mem_waitrequest) begin
                    state_nxt = DONE;
                end else if (TIMEOUT != 0 && cnt_inc == TO_LIM) begin
                    timeout_hit = 1'b1;
                    state_nxt   = DONE;
                end
            end
            DONE: begin
                result_valid = ok_q;
                fault        = |cause_q;
                fault_cause  = cause_q;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rt_q     <= '0;
            result_q <= '0;
            cause_q  <= 2'b00;
            ok_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        op_q    <= op_type;
                        addr_q  <= op_addr;
                        wdata_q <= op_wdata;
                        rt_q    <= op_rt_old;
                        cnt_q   <= '0;
                        ok_q    <= 1'b0;
                        cause_q <= misaligned(op_type, op_addr[1:0]) ? 2'b01 : 2'b00;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        if (is_load(op_q)) begin
                            result_q <= load_result(op_q, k_q, mem_readdata, rt_q);
                            ok_q     <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) cause_q <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit against a byte-level model
module tb_mem_access_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic [3:0]  op_type = '0;
    logic [31:0] op_addr = '0;
    logic [31:0] op_wdata = '0;
    logic [31:0] op_rt_old = '0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result_data;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic        mem_waitrequest = 1'b0;

    typedef struct packed {
        logic        rv;
        logic        f;
        logic [1:0]  cause;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    resp_t       rq[$];
    bus_t        bq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_load = '0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_rt_old(op_rt_old),
        .stall(stall), .result_valid(result_valid), .result_data(result_data),
        .fault(fault), .fault_cause(fault_cause), .mem_address(mem_address),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [3:0] op, input int k,
                                               input logic [31:0] w, input logic [31:0] rt);
        logic [7:0] wb[4];
        logic [7:0] rb[4];
        for (int i = 0; i < 4; i++) begin
            wb[i] = w[8*i +: 8];
            rb[i] = rt[8*i +: 8];
        end
        case (op)
            4'd0: return {{24{wb[k][7]}}, wb[k]};
            4'd1: return {24'h0, wb[k]};
            4'd2: return {{16{wb[k+1][7]}}, wb[k+1], wb[k]};
            4'd3: return {16'h0, wb[k+1], wb[k]};
            4'd5: begin
                for (int i = 0; i <= k; i++) rb[3-k+i] = wb[i];
                return {rb[3], rb[2], rb[1], rb[0]};
            end
            4'd6: begin
                for (int i = 0; i <= 3 - k; i++) rb[i] = wb[k+i];
                return {rb[3], rb[2], rb[1], rb[0]};
            end
            default: return w;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rt, input logic [31:0] rd, input int nwait);
        int    k = int'(addr[1:0]);
        int    size;
        bit    ld, st, mis;
        int    exp_d, exp_req, d, req;
        resp_t r;
        bus_t  b;
        ld   = (op <= 4'd6);
        st   = (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
        size = (op == 4'd2 || op == 4'd3 || op == 4'd9) ? 2 :
               (op == 4'd4 || op == 4'd10) ? 4 : 1;
        mis  = (ld || st) && (k % size != 0);

        @(negedge clk);
        check("result_hold", result_data, last_load);
        exp_d   = 1;
        exp_req = 0;
        if (mis) begin
            r = '{rv: 1'b0, f: 1'b1, cause: 2'b01, data: 32'h0};
            rq.push_back(r);
        end else if (ld || st) begin
            if (nwait >= TMO) begin
                r = '{rv: 1'b0, f: 1'b1, cause: 2'b10, data: 32'h0};
                rq.push_back(r);
                exp_req = TMO;
                exp_d   = TMO + 1;
            end else begin
                exp_req = nwait + 1;
                exp_d   = nwait + 2;
                b.we    = st;
                b.addr  = {addr[31:2], 2'b00};
                b.be    = 4'hF;
                b.wd    = '0;
                if (st) begin
                    for (int i = 0; i < 4; i++) begin
                        b.be[i]        = (i >= k) && (i < k + size);
                        b.wd[8*i +: 8] = wd[8*(i % size) +: 8];
                    end
                end
                bq.push_back(b);
                if (ld) begin
                    r = '{rv: 1'b1, f: 1'b0, cause: 2'b00, data: model_load(op, k, rd, rt)};
                    rq.push_back(r);
                    last_load = r.data;
                end
            end
        end

        op_type         = op;
        op_addr         = addr;
        op_wdata        = wd;
        op_rt_old       = rt;
        mem_readdata    = rd;
        mem_waitrequest = 1'b0;
        op_valid        = 1'b1;
        #1;
        check("stall_accept", 32'(stall), 32'd1);
        d   = 0;
        req = 0;
        while (d < 60) begin
            @(negedge clk);
            d++;
            if (!stall) break;
            if (mem_read || mem_write) begin
                mem_waitrequest = (req < nwait);
                req++;
            end
        end
        check("latency", 32'(d), 32'(exp_d));
        check("req_cycles", 32'(req), 32'(exp_req));
        op_valid        = 1'b0;
        mem_waitrequest = 1'b0;
    endtask

    initial begin : monitor
        resp_t r;
        bus_t  b;
        forever begin
            @(negedge clk);
            #1;
            check("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (bq.size() == 0) begin
                    check("bus_unexpected", 32'({mem_read, mem_write}), 32'd0);
                end else begin
                    b = bq.pop_front();
                    check("bus_write", 32'(mem_write), 32'(b.we));
                    check("bus_read", 32'(mem_read), 32'(!b.we));
                    check("bus_addr", mem_address, b.addr);
                    check("bus_be", 32'(mem_byteenable), 32'(b.be));
                    if (b.we) check("bus_wdata", mem_writedata, b.wd);
                end
            end
            if (result_valid || fault) begin
                if (rq.size() == 0) begin
                    check("resp_unexpected", 32'({result_valid, fault}), 32'd0);
                end else begin
                    r = rq.pop_front();
                    check("resp_valid", 32'(result_valid), 32'(r.rv));
                    check("resp_fault", 32'(fault), 32'(r.f));
                    check("resp_cause", 32'(fault_cause), 32'(r.cause));
                    if (r.rv) check("resp_data", result_data, r.data);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] op;
        int         nw;
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'(|{stall, result_valid, result_data, fault, fault_cause,
                                     mem_address, mem_read, mem_write, mem_byteenable,
                                     mem_writedata}), 32'd0);
        reset = 1'b0;

        do_op(4'd4,  32'h0000_0100, 32'h0, 32'h0, 32'h4433_2211, 0);
        do_op(4'd0,  32'h0000_0103, 32'h0, 32'h0, 32'h8033_2211, 0);
        do_op(4'd1,  32'h0000_0103, 32'h0, 32'h0, 32'h8033_2211, 1);
        do_op(4'd2,  32'h0000_0102, 32'h0, 32'h0, 32'h8033_2211, 0);
        do_op(4'd9,  32'h0000_0202, 32'h1234_ABCD, 32'h0, 32'h0, 3);
        do_op(4'd5,  32'h0000_0101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 0);
        do_op(4'd6,  32'h0000_0101, 32'h0, 32'hAABB_CCDD, 32'h4433_2211, 2);
        do_op(4'd4,  32'h0000_0101, 32'h0, 32'h0, 32'h4433_2211, 0);
        do_op(4'd4,  32'h0000_0300, 32'h0, 32'h0, 32'h5555_AAAA, 20);
        do_op(4'd7,  32'h0000_0400, 32'h0, 32'h0, 32'h0, 0);
        do_op(4'd8,  32'h0000_0401, 32'h0000_00EE, 32'h0, 32'h0, 0);

        @(negedge clk);
        op_type   = 4'd4;
        op_addr   = 32'h0000_0500;
        op_valid  = 1'b1;
        @(negedge clk);
        check("rst_req_read", 32'(mem_read), 32'd1);
        mem_waitrequest = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_drop_read", 32'(mem_read), 32'd0);
        check("rst_drop_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset           = 1'b0;
        op_valid        = 1'b0;
        mem_waitrequest = 1'b0;
        last_load       = '0;

        for (int n = 0; n < 250; n++) begin
            op = 4'($urandom_range(0, 15));
            nw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            do_op(op, $urandom, $urandom, $urandom, $urandom, nw);
        end

        repeat (3) @(negedge clk);
        check("resp_queue_empty", 32'(rq.size()), 32'd0);
        check("bus_queue_empty", 32'(bq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
